// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU multiply datapath: engine selects, default
// operand width and the per-engine state encoding.
`default_nettype none

package mmu_pkg;

  localparam int W_DEFAULT = 8;

  localparam logic [1:0] SEL_DSP   = 2'b00;
  localparam logic [1:0] SEL_BOOTH = 2'b01;
  localparam logic [1:0] SEL_BIT   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } eng_state_t;

endpackage

`default_nettype wire

// File: rtl/booth_radix2_core.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per cycle,
// product and done pulse one cycle after the last step.
`default_nettype none

module booth_radix2_core
  import mmu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [W-1:0]   A,
  input  logic signed [W-1:0]   B,
  output logic signed [2*W-1:0] P,
  output logic                  done
);

  localparam int CW = $clog2(W) + 1;

  eng_state_t          state;
  logic signed [W:0]   acc;
  logic signed [W:0]   m;
  logic [W-1:0]        q;
  logic                q_1;
  logic [CW-1:0]       cnt;
  logic signed [W:0]   sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      P     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            m     <= {A[W-1], A};
            q     <= B;
            q_1   <= 1'b0;
            cnt   <= CW'(W);
            state <= BUSY;
          end
        end
        BUSY: begin
          // Arithmetic right shift of {acc, q, q_1} applied to the updated acc.
          acc <= {sum[W], sum[W:1]};
          q   <= {sum[0], q[W-1:1]};
          q_1 <= q[0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          P     <= {acc[W-1:0], q};
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_engine_bank.sv
// Bank of three independent signed multipliers (single-cycle DSP, radix-2 Booth,
// LSB-first bit-serial) sharing operand inputs, each with its own start/done.
`default_nettype none

module mult_engine_bank
  import mmu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [W-1:0]   A,
  input  logic signed [W-1:0]   B,
  input  logic                  start_dsp,
  input  logic                  start_booth,
  input  logic                  start_bit,
  output logic signed [2*W-1:0] P_dsp,
  output logic signed [2*W-1:0] P_booth,
  output logic signed [2*W-1:0] P_bit,
  output logic                  done_dsp,
  output logic                  done_booth,
  output logic                  done_bit
);

  localparam int CW = $clog2(W) + 1;

  logic                dsp_busy;
  logic signed [W-1:0] dsp_a;
  logic signed [W-1:0] dsp_b;

  // The completing cycle may also accept the next start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dsp_busy <= 1'b0;
      dsp_a    <= '0;
      dsp_b    <= '0;
      P_dsp    <= '0;
      done_dsp <= 1'b0;
    end else begin
      done_dsp <= 1'b0;
      if (dsp_busy) begin
        P_dsp    <= (2*W)'(dsp_a) * (2*W)'(dsp_b);
        done_dsp <= 1'b1;
      end
      if (start_dsp) begin
        dsp_a    <= A;
        dsp_b    <= B;
        dsp_busy <= 1'b1;
      end else begin
        dsp_busy <= 1'b0;
      end
    end
  end

  booth_radix2_core #(.W(W)) u_booth (
    .clk   (clk),
    .reset (reset),
    .start (start_booth),
    .A     (A),
    .B     (B),
    .P     (P_booth),
    .done  (done_booth)
  );

  eng_state_t            bit_state;
  logic signed [2*W-1:0] bit_acc;
  logic signed [2*W-1:0] bit_mc;
  logic [W-1:0]          bit_mp;
  logic [CW-1:0]         bit_i;

  // Multiplicand is shifted left and multiplier right each step, so bit i of B
  // is always at bit_mp[0] with its weight already in bit_mc.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_state <= IDLE;
      bit_acc   <= '0;
      bit_mc    <= '0;
      bit_mp    <= '0;
      bit_i     <= '0;
      P_bit     <= '0;
      done_bit  <= 1'b0;
    end else begin
      done_bit <= 1'b0;
      case (bit_state)
        IDLE: begin
          if (start_bit) begin
            bit_acc   <= '0;
            bit_mc    <= (2*W)'(A);
            bit_mp    <= B;
            bit_i     <= '0;
            bit_state <= BUSY;
          end
        end
        BUSY: begin
          if (bit_mp[0]) begin
            // MSB of a two's-complement multiplier carries negative weight.
            if (bit_i == CW'(W-1)) bit_acc <= bit_acc - bit_mc;
            else                   bit_acc <= bit_acc + bit_mc;
          end
          bit_mc <= bit_mc << 1;
          bit_mp <= bit_mp >> 1;
          bit_i  <= bit_i + CW'(1);
          if (bit_i == CW'(W-1)) bit_state <= DONE;
        end
        DONE: begin
          P_bit     <= bit_acc;
          done_bit  <= 1'b1;
          bit_state <= IDLE;
        end
        default: bit_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_engine_bank.sv
// Directed and random checks of the three multiply engines in mult_engine_bank.
`timescale 1ns/1ps
`default_nettype none

module tb_mult_engine_bank;
  import mmu_pkg::*;

  localparam int W = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic signed [W-1:0]   A = '0;
  logic signed [W-1:0]   B = '0;
  logic                  start_dsp = 1'b0;
  logic                  start_booth = 1'b0;
  logic                  start_bit = 1'b0;
  logic signed [2*W-1:0] P_dsp, P_booth, P_bit;
  logic                  done_dsp, done_booth, done_bit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_engine_bank #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .A           (A),
    .B           (B),
    .start_dsp   (start_dsp),
    .start_booth (start_booth),
    .start_bit   (start_bit),
    .P_dsp       (P_dsp),
    .P_booth     (P_booth),
    .P_bit       (P_bit),
    .done_dsp    (done_dsp),
    .done_booth  (done_booth),
    .done_bit    (done_bit)
  );

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input logic [1:0] sel);
    case (sel)
      SEL_DSP:   return done_dsp;
      SEL_BOOTH: return done_booth;
      default:   return done_bit;
    endcase
  endfunction

  function automatic logic signed [2*W-1:0] get_p(input logic [1:0] sel);
    case (sel)
      SEL_DSP:   return P_dsp;
      SEL_BOOTH: return P_booth;
      default:   return P_bit;
    endcase
  endfunction

  task automatic set_start(input logic [1:0] sel, input logic v);
    case (sel)
      SEL_DSP:   start_dsp = v;
      SEL_BOOTH: start_booth = v;
      default:   start_bit = v;
    endcase
  endtask

  // Start one engine, scramble operands, then measure latency and product.
  task automatic run_one(input logic [1:0] sel, input logic signed [W-1:0] a,
                         input logic signed [W-1:0] b,
                         input logic signed [2*W-1:0] exp, input string tag);
    int n;
    int lat;
    n   = 0;
    lat = (sel == SEL_DSP) ? 1 : W + 1;
    A = a;
    B = b;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    A = ~a;
    B = ~b;
    while (!get_done(sel) && n < 4 * W) begin
      tick();
      n++;
    end
    check_val({tag, "_lat"}, n, lat);
    check_val({tag, "_p"}, get_p(sel), exp);
    tick();
    check_val({tag, "_pulse"}, {31'b0, get_done(sel)}, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [W-1:0]   va[4];
    logic signed [W-1:0]   vb[4];
    logic signed [2*W-1:0] vp[4];
    int td, tbo, tbi, dones;

    va = '{-8'sd128, 8'sd127, -8'sd1, 8'sd0};
    vb = '{-8'sd128, -8'sd128, -8'sd1, 8'sd4};
    vp = '{16'sd16384, -16'sd16256, 16'sd1, 16'sd0};

    reset = 1'b0;
    tick();
    tick();
    check_val("rst_p_dsp", P_dsp, 0);
    check_val("rst_p_booth", P_booth, 0);
    check_val("rst_p_bit", P_bit, 0);
    check_val("rst_done", {29'b0, done_dsp, done_booth, done_bit}, 0);
    reset = 1'b1;
    tick();

    run_one(SEL_DSP, 8'sd2, 8'sd1, 16'sd2, "dsp_2x1");
    run_one(SEL_DSP, 8'sd3, 8'sd5, 16'sd15, "dsp_3x5");

    for (int i = 0; i < 4; i++) begin
      run_one(SEL_BOOTH, va[i], vb[i], vp[i], $sformatf("booth_v%0d", i));
      run_one(SEL_BIT, va[i], vb[i], vp[i], $sformatf("bit_v%0d", i));
      run_one(SEL_DSP, va[i], vb[i], vp[i], $sformatf("dsp_v%0d", i));
    end

    // All three engines concurrently.
    A = 8'sd4;
    B = 8'sd2;
    start_dsp = 1'b1;
    start_booth = 1'b1;
    start_bit = 1'b1;
    tick();
    start_dsp = 1'b0;
    start_booth = 1'b0;
    start_bit = 1'b0;
    A = -8'sd7;
    td = -1;
    tbo = -1;
    tbi = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done_dsp && td < 0) td = c;
      if (done_booth && tbo < 0) tbo = c;
      if (done_bit && tbi < 0) tbi = c;
    end
    check_val("conc_lat_dsp", td, 1);
    check_val("conc_lat_booth", tbo, W + 1);
    check_val("conc_lat_bit", tbi, W + 1);
    check_val("conc_p_dsp", P_dsp, 8);
    check_val("conc_p_booth", P_booth, 8);
    check_val("conc_p_bit", P_bit, 8);

    // Second start while Booth is busy is ignored.
    A = 8'sd3;
    B = 8'sd3;
    start_booth = 1'b1;
    tick();
    start_booth = 1'b0;
    tick();
    tick();
    A = 8'sd5;
    B = 8'sd5;
    start_booth = 1'b1;
    tick();
    start_booth = 1'b0;
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (done_booth) dones++;
    end
    check_val("restart_dones", dones, 1);
    check_val("restart_p", P_booth, 9);

    // Reset in the middle of a Booth operation.
    A = 8'sd7;
    B = 8'sd7;
    start_booth = 1'b1;
    tick();
    start_booth = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done_booth) dones++;
    end
    check_val("midrst_dones", dones, 0);
    check_val("midrst_p", P_booth, 0);
    run_one(SEL_BOOTH, 8'sd6, 8'sd7, 16'sd42, "after_rst_booth");

    for (int i = 0; i < 300; i++) begin
      logic signed [W-1:0]   ra, rb;
      logic signed [2*W-1:0] rp;
      ra = W'($urandom);
      rb = W'($urandom);
      rp = ra * rb;
      run_one(SEL_DSP, ra, rb, rp, "rnd_dsp");
      run_one(SEL_BOOTH, ra, rb, rp, "rnd_booth");
      run_one(SEL_BIT, ra, rb, rp, "rnd_bit");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
